// File: rtl/mdio_master_if.sv
// mdio_master_if: request/status handshake and MDIO pad signals of the MDIO master
interface mdio_master_if;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  logic        BUSY;
  logic        ERR;
  modport master (
    input  MDIO_START, T_DATA, MDIO_IN,
    output MDC, MDIO_OE, MDIO_OUT, RD_DATA, DATA_RDY, BUSY, ERR
  );
  modport slave (
    output MDIO_START, T_DATA, MDIO_IN,
    input  MDC, MDIO_OE, MDIO_OUT, RD_DATA, DATA_RDY, BUSY, ERR
  );
endinterface

// File: rtl/mdio_master.sv
// mdio_master: clause 22/45 MDIO frame master with preamble, turnaround and read capture
module mdio_master #(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32
) (
  input logic          clk,
  input logic          rst,
  mdio_master_if.master m
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRE   = 2'd1;
  localparam logic [1:0] FRAME = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [8:0] HALF = 9'(CLK_DIV);
  localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);
  logic [1:0]  state;
  logic [8:0]  cyc;
  logic [5:0]  bit_idx;
  logic [31:0] tx;
  logic [16:0] rx;
  logic        rd;
  logic        oe;
  logic        out;
  logic [15:0] rd_data;
  logic        data_rdy;
  logic        err;
  logic        busy;
  logic        accept;
  logic        valid;
  logic        bit_end;
  logic        mdc_rise;
  logic        rx_off;
  // request decode and bit-period timing strobes
  always_comb begin
    busy     = state == PRE || state == FRAME;
    accept   = m.MDIO_START && !busy;
    valid    = m.T_DATA[31:30] == 2'b00 || (m.T_DATA[31:30] == 2'b01 && m.T_DATA[29] != m.T_DATA[28]);
    bit_end  = cyc == LAST;
    mdc_rise = cyc == HALF - 9'd1;
    rx_off   = rd && bit_idx >= 6'd13;
  end
  // frame sequencer: preamble, 32 frame bits, then a one-cycle completion state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cyc      <= 9'd0;
      bit_idx  <= 6'd0;
      tx       <= 32'd0;
      rx       <= 17'd0;
      rd       <= 1'b0;
      oe       <= 1'b0;
      out      <= 1'b0;
      rd_data  <= 16'd0;
      data_rdy <= 1'b0;
      err      <= 1'b0;
    end else begin
      data_rdy <= 1'b0;
      err      <= 1'b0;
      if (busy) cyc <= bit_end ? 9'd0 : cyc + 9'd1;
      if (state == FRAME && rd && mdc_rise && bit_idx >= 6'd15) rx <= {rx[15:0], m.MDIO_IN};
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept && !valid) err <= 1'b1;
          else if (accept) begin
            state   <= PRE_LEN == 0 ? FRAME : PRE;
            cyc     <= 9'd0;
            bit_idx <= 6'd0;
            tx      <= m.T_DATA;
            rd      <= m.T_DATA[29];
            oe      <= 1'b1;
            out     <= PRE_LEN == 0 ? m.T_DATA[31] : 1'b1;
          end
        end
        PRE: if (bit_end) begin
          bit_idx <= bit_idx == PRE_LAST ? 6'd0 : bit_idx + 6'd1;
          state   <= bit_idx == PRE_LAST ? FRAME : PRE;
          out     <= bit_idx == PRE_LAST ? tx[31] : 1'b1;
        end
        FRAME: if (bit_end) begin
          if (bit_idx == 6'd31) begin
            state    <= DONE;
            oe       <= 1'b0;
            out      <= 1'b0;
            rd_data  <= rd ? rx[15:0] : rd_data;
            data_rdy <= rd;
            err      <= rd && rx[16];
          end else begin
            bit_idx <= bit_idx + 6'd1;
            tx      <= {tx[30:0], 1'b0};
            oe      <= !rx_off;
            out     <= rx_off ? 1'b0 : tx[30];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign m.BUSY     = busy;
  assign m.MDC      = busy && cyc >= HALF;
  assign m.MDIO_OE  = oe;
  assign m.MDIO_OUT = out;
  assign m.RD_DATA  = rd_data;
  assign m.DATA_RDY = data_rdy;
  assign m.ERR      = err;
endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning MDC half-period in clk cycles (legal 1..255).
REQ-002 The block SHALL have parameter PRE_LEN, default 32, meaning the number of preamble '1' bits sent before each frame (legal 0..32).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port MDIO_START, input, 1 bit: transaction request, sampled each cycle.
REQ-006 The block SHALL have port T_DATA, input, 32 bits: frame {ST[31:30], OP[29:28], PHYADDR[27:23], REGADDR[22:18], TA[17:16], DATA[15:0]}, captured when a request is accepted.
REQ-007 The block SHALL have port MDIO_IN, input, 1 bit: serial data from the PHY.
REQ-008 The block SHALL have port MDC, output, 1 bit: management clock.
REQ-009 The block SHALL have port MDIO_OE, output, 1 bit: pad output enable.
REQ-010 The block SHALL have port MDIO_OUT, output, 1 bit: serial data to the PHY.
REQ-011 The block SHALL have port RD_DATA, output, 16 bits: last read result.
REQ-012 The block SHALL have port DATA_RDY, output, 1 bit: one-cycle read-complete pulse.
REQ-013 The block SHALL have port BUSY, output, 1 bit: transaction in progress.
REQ-014 The block SHALL have port ERR, output, 1 bit: one-cycle error pulse.

Function
REQ-015 FSM states SHALL be IDLE, PRE, FRAME, DONE; IDLE->PRE (or ->FRAME if PRE_LEN=0) on an accepted request; PRE->FRAME after PRE_LEN bits; FRAME->DONE after 32 bits; DONE->IDLE after one cycle.
REQ-016 A request SHALL be accepted only when MDIO_START=1 and BUSY=0 (IDLE or DONE); MDIO_START while BUSY=1 SHALL be ignored, with no queuing.
REQ-017 A frame SHALL be valid if ST=00 (Clause 45, any OP) or ST=01 with OP in {01,10} (Clause 22); any other frame SHALL produce ERR=1 in the next cycle, with BUSY, MDC and MDIO_OE staying 0.
REQ-018 A transaction SHALL be a read when OP[1]=1 and a write otherwise.
REQ-019 BUSY SHALL rise in the cycle after acceptance and stay high for exactly (PRE_LEN+32)*2*CLK_DIV cycles.
REQ-020 Each bit period SHALL be MDC low for CLK_DIV cycles, then MDC high for CLK_DIV cycles; MDC SHALL be 0 whenever BUSY=0.
REQ-021 MDIO_OUT and MDIO_OE SHALL change only in the cycle MDC goes (or stays) low at a bit start.
REQ-022 Preamble bits SHALL drive MDIO_OUT=1; frame bits SHALL drive T_DATA[31] down to T_DATA[0], MSB first.
REQ-023 For writes, MDIO_OE SHALL be 1 for the entire preamble and all 32 frame bits.
REQ-024 For reads, MDIO_OE SHALL be 1 for the preamble and frame bits 31..18, and 0 for TA and data (bits 17..0); MDIO_OUT SHALL be 0 while MDIO_OE=0.
REQ-025 For reads, MDIO_IN SHALL be sampled on the clk edge where MDC rises, at frame bit 16 (TA low) and bits 15..0 shifted MSB first into RD_DATA.
REQ-026 RD_DATA SHALL update only in DONE, and SHALL hold its value through writes.
REQ-027 In DONE (first cycle with BUSY=0), a read SHALL pulse DATA_RDY=1; ERR SHALL also pulse if the sampled TA bit was 1 (no PHY response).
REQ-028 Writes SHALL never pulse DATA_RDY.
REQ-029 In DONE, MDIO_OE SHALL be 0.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL go to IDLE with MDC=0, MDIO_OE=0, MDIO_OUT=0, RD_DATA=0, DATA_RDY=0, BUSY=0, ERR=0, and all counters cleared.
REQ-031 Reset mid-transaction SHALL abort the transaction, with no DATA_RDY or ERR pulse.
REQ-032 MDIO_START asserted in the same cycle as rst SHALL be ignored.

Verification (CLK_DIV=2, PRE_LEN=32 unless stated)
REQ-033 Write check: T_DATA=0x508A1234 with a MDIO_START pulse -> BUSY high 256 cycles; 32 ones then 0101_00001_00010_10_0x1234 on MDIO_OUT; MDIO_OE=1 throughout; no DATA_RDY.
REQ-034 Read check: T_DATA=0x60880000, PHY drives TA-low 0 then 0xBEEF -> MDIO_OE falls at frame bit 17; in the cycle after BUSY falls, RD_DATA=0xBEEF, DATA_RDY=1 for 1 cycle, ERR=0.
REQ-035 No-PHY read check: same read with MDIO_IN held 1 -> RD_DATA=0xFFFF, with DATA_RDY=1 and ERR=1 in the same single cycle.
REQ-036 Invalid frame check: T_DATA=0x70880000 (ST=01, OP=11) -> ERR=1 one cycle; BUSY, MDC and MDIO_OE stay 0.
REQ-037 Busy and reset check: second MDIO_START at cycle 50 of a write -> ignored, total BUSY 256 cycles; then rst=1 at cycle 100 of a read -> next cycle all outputs at reset values, no DATA_RDY.
REQ-038 Parameter check: CLK_DIV=1, PRE_LEN=0, T_DATA=0x00000000 -> BUSY high exactly 64 cycles; MDC toggles every cycle; MDIO_OE=1 throughout.
